pipe_scoreboard_hazard: RTL and testbench

- Parametrised successor to the fixed load-use hazard logic of the 5-stage RV32I pipeline.
- Tracks per-register result availability with countdown counters, so execute-side units may have any latency from 1 to MAX_LAT (ALU, load, multi-cycle MUL).
- Sits between decode and the pipeline registers and drives stall_f, stall_d, flush_d and flush_e.
- Rolls back the scoreboard entry of a squashed instruction on a taken branch/jump, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_scoreboard_hazard.sv | 120 ++++++++++++
 tb/tb_pipe_scoreboard_hazard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard_hazard.sv
// Register scoreboard for a variable-latency in-order pipeline: per-register countdown
// of cycles until a result is forwardable, with stall/flush generation and branch rollback.
module pipe_scoreboard_hazard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                valid_d,
    input  logic [REG_AW-1:0]   rs1_d,
    input  logic [REG_AW-1:0]   rs2_d,
    input  logic                use_rs1_d,
    input  logic                use_rs2_d,
    input  logic [REG_AW-1:0]   rd_d,
    input  logic                reg_write_d,
    input  logic [LAT_W-1:0]    lat_d,
    input  logic                pcsrc_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_d,
    output logic                flush_e,
    output logic [NUM_REGS-1:0] busy_map,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0]  cnt_q [NUM_REGS];
    logic [LAT_W-1:0]  cnt_d [NUM_REGS];
    logic              last_vld_q, last_vld_d;
    logic [REG_AW-1:0] last_rd_q, last_rd_d;
    logic [LAT_W-1:0]  last_prev_q, last_prev_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic [LAT_W-1:0]  lat_eff;
    logic              raw, waw, hz, issue, issue_wr;

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
        return (v == '0) ? '0 : v - LAT_ONE;
    endfunction

    always_comb begin
        lat_eff = lat_d;
        if (lat_d == '0)
            lat_eff = LAT_ONE;
        else if (lat_d > LAT_MAX)
            lat_eff = LAT_MAX;
    end

    // x0 is excluded explicitly even though its counter is never written
    always_comb begin
        raw = valid_d &
              ((use_rs1_d & (rs1_d != '0) & (cnt_q[rs1_d] != '0)) |
               (use_rs2_d & (rs2_d != '0) & (cnt_q[rs2_d] != '0)));
        waw = valid_d & reg_write_d & (rd_d != '0) & (cnt_q[rd_d] >= lat_eff);
        hz       = (raw | waw) & ~pcsrc_e;
        issue    = valid_d & ~hz & ~pcsrc_e;
        issue_wr = issue & reg_write_d & (rd_d != '0);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            cnt_d[i] = sat_dec(cnt_q[i]);
        last_vld_d  = 1'b0;
        last_rd_d   = last_rd_q;
        last_prev_d = last_prev_q;

        if (issue_wr) begin
            cnt_d[rd_d] = lat_eff - LAT_ONE;
            last_vld_d  = 1'b1;
            last_rd_d   = rd_d;
            last_prev_d = sat_dec(cnt_q[rd_d]);
        end

        // restore the older writer's countdown as it would have been after this edge
        if (pcsrc_e && last_vld_q)
            cnt_d[last_rd_q] = sat_dec(last_prev_q);

        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt_q[i] <= '0;
            last_vld_q  <= 1'b0;
            last_rd_q   <= '0;
            last_prev_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt_q[i] <= cnt_d[i];
            last_vld_q  <= last_vld_d;
            last_rd_q   <= last_rd_d;
            last_prev_q <= last_prev_d;
            if (hz && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (pcsrc_e && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        stall_f = hz & ~srst;
        stall_d = hz & ~srst;
        flush_d = pcsrc_e & ~srst;
        flush_e = (hz | pcsrc_e) & ~srst;
        for (int i = 0; i < NUM_REGS; i++)
            busy_map[i] = (cnt_q[i] != '0) & ~srst;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_scoreboard_hazard.sv
// Directed bench for pipe_scoreboard_hazard: ALU/load/MUL latencies, x0, rollback, WAW, async reset.
module tb_pipe_scoreboard_hazard;

    logic        clk = 1'b0;
    logic        srst;
    logic        valid_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        use_rs1_d, use_rs2_d, reg_write_d;
    logic [2:0]  lat_d;
    logic        pcsrc_e;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [31:0] busy_map;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipe_scoreboard_hazard dut (
        .clk(clk), .srst(srst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .lat_d(lat_d), .pcsrc_e(pcsrc_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .busy_map(busy_map), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_d = 0; rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0;
        rd_d = 0; reg_write_d = 0; lat_d = 0; pcsrc_e = 0;
    endtask

    task automatic producer(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        valid_d = 1; rd_d = rd; reg_write_d = 1; lat_d = lat;
    endtask

    task automatic consumer1(input logic [4:0] rs);
        idle();
        valid_d = 1; rs1_d = rs; use_rs1_d = 1;
    endtask

    task automatic hz_vec(input string tag, input logic exp);
        chk({tag, "_stall_f"}, stall_f, exp);
        chk({tag, "_stall_d"}, stall_d, exp);
        chk({tag, "_flush_e"}, flush_e, exp);
    endtask

    initial begin
        idle();
        srst = 1;
        tick(); tick();
        chk("rst_busy", busy_map, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_flush_d", flush_d, 0);
        srst = 0;
        tick();

        // ALU chain: no stall
        producer(5, 1);
        #1 hz_vec("alu_prod", 0);
        tick();
        consumer1(5);
        #1 hz_vec("alu_cons", 0);
        chk("alu_busy", busy_map, 0);
        tick();

        // Load-use: exactly one bubble
        producer(5, 2);
        tick();
        idle(); valid_d = 1; rs2_d = 5; use_rs2_d = 1;
        #1 hz_vec("lu_bubble", 1);
        chk("lu_busy", busy_map, 32'h0000_0020);
        tick();
        #1 hz_vec("lu_issue", 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        tick();

        // MUL latency 4, then again with lat 7 clamped to 4
        for (int r = 0; r < 2; r++) begin
            producer(7, (r == 0) ? 3'd4 : 3'd7);
            tick();
            consumer1(7);
            for (int c = 0; c < 3; c++) begin
                #1 hz_vec("mul_stall", 1);
                chk("mul_busy7", busy_map[7], 1);
                tick();
            end
            #1 hz_vec("mul_issue", 0);
            chk("mul_busy_clear", busy_map, 0);
            chk("mul_stall_cnt", stall_cnt, (r == 0) ? 4 : 7);
            tick();
        end

        // x0 never busy
        producer(0, 4);
        tick();
        chk("x0_busy", busy_map, 0);
        consumer1(0);
        #1 hz_vec("x0_cons", 0);
        tick();

        // Rollback of squashed writer to x9
        producer(9, 4);
        tick();
        consumer1(9);
        pcsrc_e = 1;
        #1 chk("rb_flush_d", flush_d, 1);
        chk("rb_flush_e", flush_e, 1);
        chk("rb_stall_f", stall_f, 0);
        chk("rb_busy9_pre", busy_map[9], 1);
        tick();
        pcsrc_e = 0;
        #1 chk("rb_busy9_post", busy_map[9], 0);
        chk("rb_flush_cnt", flush_cnt, 1);
        hz_vec("rb_cons", 0);
        chk("rb_stall_cnt", stall_cnt, 7);
        tick();

        // WAW on x3 with a branch during the second stall cycle
        producer(3, 4);
        tick();
        producer(3, 1);
        #1 hz_vec("waw_c1", 1);
        tick();
        pcsrc_e = 1;
        #1 chk("waw_c2_stall_f", stall_f, 0);
        chk("waw_c2_flush_e", flush_e, 1);
        chk("waw_c2_flush_d", flush_d, 1);
        tick();
        pcsrc_e = 0;
        #1 hz_vec("waw_c3", 1);
        chk("waw_c3_busy3", busy_map[3], 1);
        tick();
        #1 hz_vec("waw_issue", 0);
        chk("waw_stall_cnt", stall_cnt, 9);
        chk("waw_flush_cnt", flush_cnt, 2);
        tick();
        idle();
        #1 chk("waw_busy_after", busy_map, 0);

        // Asynchronous reset in the middle of a stall
        producer(10, 4);
        tick();
        consumer1(10);
        #1 hz_vec("ar_pre", 1);
        #1 srst = 1;
        pcsrc_e = 1;
        #1 hz_vec("ar_in", 0);
        chk("ar_flush_d", flush_d, 0);
        chk("ar_busy", busy_map, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
        chk("ar_flush_cnt", flush_cnt, 0);
        tick();
        srst = 0;
        pcsrc_e = 0;
        #1 hz_vec("ar_post", 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
